// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the PC, captures ROM words into the IR and hands them to decode
// over valid/ready. Resolves unconditional jumps locally and obeys redirect/halt from execute.
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned INSTR_W     = 16,
    parameter logic [3:0]  JUMP_OPCODE = 4'b1011,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_instr,
    output logic [ADDR_W-1:0]  ir_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted,
    output logic [7:0]         fetch_count
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OPC_W = 4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic [INSTR_W-1:0] ir_instr_q, ir_instr_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               halted_q, halted_d;
    logic               cap;

    // Next-state and capture logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_valid_d = ir_valid_q;
        ir_instr_d = ir_instr_q;
        ir_pc_d    = ir_pc_q;
        count_d    = count_q;
        halted_d   = halted_q;
        cap        = 1'b0;

        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                if (ir_ready) ir_valid_d = 1'b0;
            end
            S_RUN: begin
                cap = !redirect_valid && (!ir_valid_q || ir_ready);
                if (redirect_valid) begin
                    // Flush regardless of ir_ready; redirect beats any capture or jump
                    pc_d       = redirect_pc;
                    ir_valid_d = 1'b0;
                end else if (cap) begin
                    ir_instr_d = imem_instr;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
                    if (imem_instr[INSTR_W-1 -: OPC_W] == JUMP_OPCODE)
                        pc_d = imem_instr[ADDR_W-1:0];
                    else
                        pc_d = pc_q + ADDR_W'(1);
                end
                if (halt) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end
            end
            S_HALT: begin
                if (ir_ready) ir_valid_d = 1'b0;
            end
            default: state_d = S_BOOT;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            ir_valid_q <= 1'b0;
            ir_instr_q <= '0;
            ir_pc_q    <= '0;
            count_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_valid_q <= ir_valid_d;
            ir_instr_q <= ir_instr_d;
            ir_pc_q    <= ir_pc_d;
            count_q    <= count_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_addr   = pc_q;
    assign ir_valid    = ir_valid_q;
    assign ir_instr    = ir_instr_q;
    assign ir_pc       = ir_pc_q;
    assign fetch_count = count_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        ir_valid;
    logic        ir_ready;
    logic [15:0] ir_instr;
    logic [3:0]  ir_pc;
    logic        redirect_valid;
    logic [3:0]  redirect_pc;
    logic        halt;
    logic        halted;
    logic [7:0]  fetch_count;

    logic [15:0] rom [16];
    int checks = 0;
    int errors = 0;

    // Reference model state: phase 0 = boot bubble, 1 = running, 2 = halted
    int          m_pc, m_irpc, m_cnt, m_phase;
    logic        m_valid;
    logic [15:0] m_instr;
    logic        model_ok = 1'b0;

    instruction_fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
        .halted(halted), .fetch_count(fetch_count)
    );

    assign imem_instr = rom[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Model advances on the same edge the DUT samples its inputs
    always @(posedge clk) begin : model
        logic [15:0] w;
        if (reset) begin
            m_pc <= 0; m_irpc <= 0; m_cnt <= 0; m_phase <= 0;
            m_valid <= 1'b0; m_instr <= '0; model_ok <= 1'b1;
        end else if (model_ok) begin
            w = rom[m_pc];
            if (m_phase == 0) begin
                m_phase <= 1;
                if (ir_ready) m_valid <= 1'b0;
            end else if (m_phase == 1) begin
                if (redirect_valid) begin
                    m_pc <= int'(redirect_pc);
                    m_valid <= 1'b0;
                end else if (!m_valid || ir_ready) begin
                    m_valid <= 1'b1;
                    m_instr <= w;
                    m_irpc  <= m_pc;
                    m_cnt   <= (m_cnt < 255) ? m_cnt + 1 : 255;
                    m_pc    <= (w[15:12] == 4'hB) ? int'(w[3:0]) : (m_pc + 1) % 16;
                end
                if (halt) m_phase <= 2;
            end else begin
                if (ir_ready) m_valid <= 1'b0;
            end
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        if (model_ok) begin
            chk("imem_addr", int'(imem_addr), m_pc);
            chk("ir_valid", int'(ir_valid), int'(m_valid));
            chk("halted", int'(halted), (m_phase == 2) ? 1 : 0);
            chk("fetch_count", int'(fetch_count), m_cnt);
            if (m_valid) begin
                chk("ir_instr", int'(ir_instr), int'(m_instr));
                chk("ir_pc", int'(ir_pc), m_irpc);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset for two cycles, then consume the boot bubble
    task automatic do_reset();
        reset = 1'b1; ir_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    initial begin
        reset = 1'b1; ir_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = (i < 8) ? 16'(16'h1000 + i) : 16'(16'h2000 + i);
        rom[7] = 16'hB000;

        // Sequential fetch with a jump at 7 back to 0
        do_reset();
        chk("boot_valid", int'(ir_valid), 0);
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            chk("seq_ir_pc", int'(ir_pc), (k < 8) ? k : k - 8);
            if (k == 7) chk("jump_word", int'(ir_instr), 16'hB000);
        end
        chk("count10", int'(fetch_count), 10);

        // Stall while ir_pc = 2
        cyc(1);
        chk("pre_stall_pc", int'(ir_pc), 2);
        chk("pre_stall_addr", int'(imem_addr), 3);
        ir_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1);
            chk("stall_ir_pc", int'(ir_pc), 2);
            chk("stall_addr", int'(imem_addr), 3);
            chk("stall_instr", int'(ir_instr), 16'h1002);
        end
        ir_ready = 1'b1;
        cyc(1);
        chk("release_pc3", int'(ir_pc), 3);
        cyc(1);
        chk("release_pc4", int'(ir_pc), 4);

        // Redirect to 5 while ir_pc = 1, hold decode stalled to prove the flush
        do_reset();
        cyc(2);
        chk("redir_pre_pc", int'(ir_pc), 1);
        redirect_valid = 1'b1; redirect_pc = 4'd5; ir_ready = 1'b0;
        cyc(1);
        redirect_valid = 1'b0; ir_ready = 1'b1;
        chk("redir_flush", int'(ir_valid), 0);
        chk("redir_addr", int'(imem_addr), 5);
        cyc(1);
        chk("redir_ir_pc", int'(ir_pc), 5);
        chk("redir_valid", int'(ir_valid), 1);

        // Jump-free program: wrap and counter saturation
        reset = 1'b1;
        rom[7] = 16'h7000;
        do_reset();
        cyc(16);
        chk("wrap_pc15", int'(ir_pc), 15);
        cyc(1);
        chk("wrap_pc0", int'(ir_pc), 0);
        cyc(283);
        chk("sat_count", int'(fetch_count), 255);
        rom[7] = 16'hB000;

        // Halt at ir_pc = 3
        do_reset();
        cyc(4);
        chk("halt_pre_pc", int'(ir_pc), 3);
        halt = 1'b1;
        cyc(1);
        halt = 1'b0;
        chk("halt_cap_pc", int'(ir_pc), 4);
        chk("halt_flag", int'(halted), 1);
        chk("halt_addr", int'(imem_addr), 5);
        ir_ready = 1'b0;
        cyc(1);
        chk("halt_hold_valid", int'(ir_valid), 1);
        ir_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 4'd9;
        cyc(2);
        redirect_valid = 1'b0;
        chk("halt_clear_valid", int'(ir_valid), 0);
        chk("halt_frozen_addr", int'(imem_addr), 5);
        chk("halt_count", int'(fetch_count), 5);

        // Redirect and halt together
        do_reset();
        cyc(1);
        redirect_valid = 1'b1; redirect_pc = 4'd9; halt = 1'b1;
        cyc(1);
        redirect_valid = 1'b0; halt = 1'b0;
        chk("rh_addr", int'(imem_addr), 9);
        chk("rh_halted", int'(halted), 1);
        chk("rh_valid", int'(ir_valid), 0);

        // Reset in the middle of a stall
        do_reset();
        cyc(2);
        ir_ready = 1'b0;
        cyc(1);
        chk("rst_pre_valid", int'(ir_valid), 1);
        reset = 1'b1; ir_ready = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("rst_valid", int'(ir_valid), 0);
        chk("rst_addr", int'(imem_addr), 0);
        chk("rst_count", int'(fetch_count), 0);
        cyc(1);
        chk("rst_bubble", int'(ir_valid), 0);
        cyc(1);
        chk("rst_first_pc", int'(ir_pc), 0);
        chk("rst_first_valid", int'(ir_valid), 1);

        cyc(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
